// File: rtl/ramb16_gearbox_pkg.sv
// Shared widths and read-FSM encoding for the 2-bit-in / 32-bit-out block-RAM gearbox.
package ramb16_gearbox_pkg;

  localparam int SYM_W         = 2;
  localparam int WORD_W        = 32;
  localparam int SYMS_PER_WORD = 16;
  localparam int ADDRA_W       = 13;
  localparam int ADDRB_W       = 9;
  localparam int LEVEL_W       = 14;
  localparam int WORDS_W       = LEVEL_W - 4;

  localparam logic [LEVEL_W-1:0] DEPTH_SYM = LEVEL_W'(1 << ADDRA_W);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CAPT = 1'b1
  } rd_state_e;

endpackage

// File: rtl/ramb16_gearbox_level.sv
// Fill-level accounting in symbols: +1 per accepted symbol, -16 per released word.
module ramb16_gearbox_level
  import ramb16_gearbox_pkg::*;
#(
  parameter int AFULL_SYM    = 8064,
  parameter int AEMPTY_WORDS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               inc,
  input  logic               dec16,
  output logic [LEVEL_W-1:0] level,
  output logic [WORDS_W-1:0] words,
  output logic               full,
  output logic               almost_full,
  output logic               almost_empty
);

  localparam logic [LEVEL_W-1:0] AF_TH = LEVEL_W'(AFULL_SYM);
  localparam logic [WORDS_W-1:0] AE_TH = WORDS_W'(AEMPTY_WORDS);

  logic [LEVEL_W-1:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else begin
      case ({inc, dec16})
        2'b10:   level_d = level_q + LEVEL_W'(1);
        2'b01:   level_d = level_q - LEVEL_W'(16);
        2'b11:   level_d = level_q - LEVEL_W'(15);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= '0;
    else        level_q <= level_d;
  end

  // Whole words only; a partial tail word never counts.
  assign words        = level_q[LEVEL_W-1:4];
  assign level        = level_q;
  assign full         = (level_q == DEPTH_SYM);
  assign almost_full  = (level_q >= AF_TH);
  assign almost_empty = (words <= AE_TH);

endmodule

// File: rtl/ramb16_s2_s36_gearbox_ctrl.sv
// Gearbox FIFO controller around an 8192x2 / 512x32 dual-port block RAM.
// Define RAMB16_GEARBOX_ERR_EN to add the err_sticky / err_clr overflow-underrun flag.
module ramb16_s2_s36_gearbox_ctrl
  import ramb16_gearbox_pkg::*;
#(
  parameter int AFULL_SYM    = 8064,
  parameter int AEMPTY_WORDS = 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SYM_W-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic [LEVEL_W-1:0] level,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [ADDRA_W-1:0] ADDRA,
  output logic [SYM_W-1:0]   DIA,
  output logic               ENA,
  output logic               WEA,
  output logic [ADDRB_W-1:0] ADDRB,
  output logic               ENB,
  input  logic [WORD_W-1:0]  DOB
`ifdef RAMB16_GEARBOX_ERR_EN
  ,
  input  logic               err_clr,
  output logic               err_sticky
`endif
);

  logic               rdy_en_q;
  logic [ADDRA_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRB_W-1:0] rd_ptr_q, rd_ptr_d;
  rd_state_e          state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WORD_W-1:0]  out_data_q, out_data_d;

  logic               accept, issue, capt, full;
  logic [WORDS_W-1:0] words;

  // A word stays counted in level until CAPT, so in IDLE every counted
  // word is still unissued and port A cannot overwrite a word being read.
  assign capt     = (state_q == CAPT);
  assign in_ready = rdy_en_q && !full && !flush;
  assign accept   = in_valid && in_ready;
  assign issue    = (state_q == IDLE) && (words != '0) &&
                    (!out_valid_q || out_ready) && !flush;

  assign ENA   = accept;
  assign WEA   = accept;
  assign ADDRA = wr_ptr_q;
  assign DIA   = accept ? in_data : '0;
  assign ENB   = issue;
  assign ADDRB = rd_ptr_q;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  ramb16_gearbox_level #(
    .AFULL_SYM   (AFULL_SYM),
    .AEMPTY_WORDS(AEMPTY_WORDS)
  ) u_level (
    .clk         (CLK),
    .rst_n       (RST_N),
    .flush       (flush),
    .inc         (accept),
    .dec16       (capt && !flush),
    .level       (level),
    .words       (words),
    .full        (full),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + ADDRA_W'(1);
      if (capt) begin
        // Output slot was freed when the read was issued, so capture is unconditional.
        out_data_d  = DOB;
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + ADDRB_W'(1);
        state_d     = IDLE;
      end else begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (issue)                    state_d     = CAPT;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_en_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rdy_en_q    <= 1'b1;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef RAMB16_GEARBOX_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (err_clr || flush) begin
      err_d = 1'b0;
    end else if ((in_valid && full) ||
                 (out_ready && !out_valid_q && (state_q == IDLE) && (words == '0))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_ramb16_s2_s36_gearbox_ctrl.sv
// Randomised bench: symbol-queue reference model checked every cycle, plus literal checks.
module tb_ramb16_s2_s36_gearbox_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_data = 2'd0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, almost_full, almost_empty, ENA, WEA, ENB;
  logic [31:0] out_data;
  logic [31:0] DOB = 32'd0;
  logic [13:0] level;
  logic [12:0] ADDRA;
  logic [1:0]  DIA;
  logic [8:0]  ADDRB;
`ifdef RAMB16_GEARBOX_ERR_EN
  logic        err_clr = 1'b0;
  logic        err_sticky;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  ramb16_s2_s36_gearbox_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
    .ADDRA(ADDRA), .DIA(DIA), .ENA(ENA), .WEA(WEA),
    .ADDRB(ADDRB), .ENB(ENB), .DOB(DOB)
`ifdef RAMB16_GEARBOX_ERR_EN
    , .err_clr(err_clr), .err_sticky(err_sticky)
`endif
  );

  // Dual-port RAM: 2-bit port A, 32-bit port B, symbol k of a word at DOB[2k+1:2k].
  logic [1:0] mem [8192];
  always @(posedge CLK) begin
    if (ENA && WEA) mem[ADDRA] <= DIA;
    if (ENB) for (int k = 0; k < 16; k++) DOB[2*k +: 2] <= mem[{ADDRB, 4'(k)}];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: symbols held in a queue, words popped 16 at a time.
  int         m_level = 0, m_wr = 0, m_rd = 0;
  bit         m_ov = 0, m_fetch = 0, m_live = 0, m_err = 0;
  logic [31:0] m_od = 0, m_w;
  logic [1:0] m_q[$];
  bit         e_rdy, e_acc, e_iss;

  always @(negedge CLK) begin
    e_rdy = m_live && (m_level != 8192) && !flush;
    e_acc = in_valid && e_rdy;
    e_iss = !m_fetch && (m_level / 16 != 0) && (!m_ov || out_ready) && !flush;
    chk("in_ready", in_ready, e_rdy);
    chk("ENA", ENA, e_acc);
    chk("WEA", WEA, e_acc);
    chk("ENB", ENB, e_iss);
    chk("level", level, m_level);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("almost_full", almost_full, m_level >= 8064);
    chk("almost_empty", almost_empty, (m_level / 16) <= 1);
    if (e_acc || !RST_N) begin
      chk("ADDRA", ADDRA, m_wr);
      chk("DIA", DIA, e_acc ? in_data : 2'd0);
    end
    if (e_iss || !RST_N) chk("ADDRB", ADDRB, m_rd);
    if (ENA && ENB) chk("rw_collision", ADDRB == ADDRA[12:4], 0);
`ifdef RAMB16_GEARBOX_ERR_EN
    chk("err_sticky", err_sticky, m_err);
    if (!RST_N || err_clr || flush) m_err = 0;
    else if ((in_valid && m_level == 8192) ||
             (out_ready && !m_ov && !m_fetch && m_level / 16 == 0)) m_err = 1;
`endif
    if (!RST_N) begin
      m_level = 0; m_wr = 0; m_rd = 0; m_ov = 0; m_od = 0; m_fetch = 0; m_live = 0;
      m_q.delete();
    end else if (flush) begin
      m_level = 0; m_wr = 0; m_rd = 0; m_ov = 0; m_od = 0; m_fetch = 0; m_live = 1;
      m_q.delete();
    end else begin
      m_live = 1;
      if (m_fetch) begin
        m_w = 0;
        for (int k = 0; k < 16; k++) m_w[2*k +: 2] = m_q.pop_front();
        m_od = m_w; m_ov = 1; m_rd = (m_rd + 1) % 512; m_level -= 16;
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
      if (e_acc) begin
        m_q.push_back(in_data); m_wr = (m_wr + 1) % 8192; m_level++;
      end
      m_fetch = e_iss;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [1:0] d);
    bit ok;
    ok = 0;
    in_valid = 1; in_data = d;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge CLK);
      ok = in_ready;
      if (ok) last_acc_cyc = cyc;
      tick();
    end
    in_valid = 0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rec, n, words;
    bit saw_wa, saw_rb, found;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_almost_full", almost_full, 0);
    tick();
    RST_N = 1;
    @(negedge CLK);
    chk("rdy_before_edge", in_ready, 0);
    tick();
    @(negedge CLK);
    chk("rdy_after_edge", in_ready, 1);
    tick();

    // One word 0,1,2,3,... : latency and packing
    out_ready = 1;
    for (int k = 0; k < 16; k++) send(2'(k % 4));
    rec = -1;
    for (int i = 0; i < 8 && rec < 0; i++) begin
      @(negedge CLK);
      if (out_valid) rec = cyc;
      else tick();
    end
    chk("first_latency", rec - last_acc_cyc, 3);
    chk("first_word", out_data, 32'hE4E4E4E4);
    repeat (3) tick();
    chk("first_level0", level, 0);

    // Fill to full with consumer stalled; one word parks in the output register
    out_ready = 0;
`ifdef RAMB16_GEARBOX_ERR_EN
    err_clr = 1; tick(); err_clr = 0;
`endif
    n = 0; found = 0;
    in_valid = 1;
    for (int i = 0; i < 9000 && !found; i++) begin
      in_data = 2'($urandom);
      @(negedge CLK);
      if (in_ready) n++;
      else if (level == 14'd8192) found = 1;
      if (!found) tick();
    end
    chk("fill_accepts", n, 8192 + 16);
    chk("full_level", level, 14'd8192);
    chk("full_in_ready", in_ready, 0);
    chk("full_almost_full", almost_full, 1);
    tick();
`ifdef RAMB16_GEARBOX_ERR_EN
    @(negedge CLK);
    chk("err_overflow_set", err_sticky, 1);
    tick();
`endif
    in_valid = 0;
    repeat (3) tick();
`ifdef RAMB16_GEARBOX_ERR_EN
    chk("err_held", err_sticky, 1);
    err_clr = 1; tick(); err_clr = 0;
    @(negedge CLK);
    chk("err_cleared", err_sticky, 0);
    tick();
`endif

    // One handshake from full: writes resume the cycle after CAPT
    out_ready = 1; tick(); out_ready = 0;
    @(negedge CLK);
    chk("capt_in_ready", in_ready, 0);
    chk("capt_level", level, 14'd8192);
    tick();
    @(negedge CLK);
    chk("resume_in_ready", in_ready, 1);
    chk("resume_level", level, 14'd8176);
    tick();

    // Drain
    out_ready = 1; found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge CLK);
      found = (level == 0) && !out_valid;
      tick();
    end
    chk("drain_done", found, 1);

    // Random streaming for 1000 words, crossing both pointer wraps
    words = 0; saw_wa = 0; saw_rb = 0;
    for (int i = 0; i < 40000 && words < 1000; i++) begin
      in_valid  = ($urandom % 10) != 0;
      in_data   = 2'($urandom);
      out_ready = ($urandom % 4) != 0;
      @(negedge CLK);
      if (out_valid && out_ready) words++;
      if (ENA && ADDRA == 13'd8191) saw_wa = 1;
      if (ENB && ADDRB == 9'd511) saw_rb = 1;
      tick();
    end
    in_valid = 0; out_ready = 0;
    chk("stream_words", words, 1000);
    chk("wr_wrap_seen", saw_wa, 1);
    chk("rd_wrap_seen", saw_rb, 1);

    // Flush during CAPT discards the in-flight read
    flush = 1; tick(); flush = 0;
    for (int k = 0; k < 32; k++) send(2'($urandom));
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge CLK);
      found = out_valid && (level == 14'd16);
      tick();
    end
    chk("pre_flush_state", found, 1);
    out_ready = 1;
    @(negedge CLK);
    chk("pre_flush_issue", ENB, 1);
    tick();
    out_ready = 0; flush = 1;
    @(negedge CLK);
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 0;
    @(negedge CLK);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_level", level, 0);
    tick();
    out_ready = 1;
    for (int k = 0; k < 16; k++) send(2'($urandom));
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge CLK);
      if (ENB) begin
        found = 1;
        chk("post_flush_addrb", ADDRB, 0);
      end
      tick();
    end
    chk("post_flush_issue", found, 1);
    repeat (6) tick();
    chk("post_flush_level", level, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
